// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file, 2 registered read ports, 1 write port, busy scoreboard.
// Latency: 1 cycle from readSel_n to readOut_n/busy_n; write/mark take effect at the same posedge.
// Backpressure: none; re=0 freezes all four read outputs, write and mark are always accepted.
//
// Ports:
//   clock, rst            single posedge clock, synchronous active-high reset
//   re                    read enable (0 = read outputs hold)
//   readSel_1/readSel_2   read addresses; readOut_1/2 and busy_1/2 are the registered results
//   we, writeSel, data    writeback port; a write also clears the busy bit of its target
//   mark_en, mark_sel     decode-side issue; sets the busy bit of the destination register
//
// Out-of-range addresses (>= DEPTH) and, with ZERO_REG, address 0 are inert:
// writes and marks to them are dropped, reads of them return 0 / not busy.

module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] readSel_1,
    input  logic [ADDR_WIDTH-1:0] readSel_2,
    output logic [DATA_WIDTH-1:0] readOut_1,
    output logic [DATA_WIDTH-1:0] readOut_2,
    output logic                  busy_1,
    output logic                  busy_2,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] writeSel,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  mark_en,
    input  logic [ADDR_WIDTH-1:0] mark_sel
);

    // An address names real, writable storage only if it is inside the array
    // and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({{(32-ADDR_WIDTH){1'b0}}, a} < 32'(DEPTH));
        is_zero  = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    // Architectural state
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    // Read output registers, index 0 = port 1, index 1 = port 2
    logic [DATA_WIDTH-1:0] rd_dat_q [2];
    logic [DATA_WIDTH-1:0] rd_dat_d [2];
    logic [1:0]            rd_busy_q;
    logic [1:0]            rd_busy_d;

    logic [ADDR_WIDTH-1:0] rd_sel [2];

    logic wr_ok;
    logic mk_ok;

    assign wr_ok     = we && addr_ok(writeSel);
    assign mk_ok     = mark_en && addr_ok(mark_sel);
    assign rd_sel[0] = readSel_1;
    assign rd_sel[1] = readSel_2;

    // Next-state of the array and scoreboard. The mark is applied after the
    // write so that a same-cycle write+mark leaves the register busy: the
    // write retires an older producer while the mark issues a new one.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_ok) begin
            mem_d[writeSel]  = data;
            busy_d[writeSel] = 1'b0;
        end
        if (mk_ok) begin
            busy_d[mark_sel] = 1'b1;
        end
    end

    // Read-side value selection, one identical block per port.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rd_dat_d[p]  = '0;
            rd_busy_d[p] = 1'b0;
            if (addr_ok(rd_sel[p])) begin
                if ((BYPASS != 0) && wr_ok && (writeSel == rd_sel[p])) begin
                    rd_dat_d[p] = data;
                end else begin
                    rd_dat_d[p] = mem_q[rd_sel[p]];
                end

                // A fresh mark always shows as busy, independent of BYPASS,
                // so decode never misses a hazard it has just created.
                if (mk_ok && (mark_sel == rd_sel[p])) begin
                    rd_busy_d[p] = 1'b1;
                end else if ((BYPASS != 0) && wr_ok && (writeSel == rd_sel[p])) begin
                    rd_busy_d[p] = 1'b0;
                end else begin
                    rd_busy_d[p] = busy_q[rd_sel[p]];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q      <= '0;
            rd_dat_q[0] <= '0;
            rd_dat_q[1] <= '0;
            rd_busy_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q <= busy_d;
            if (re) begin
                rd_dat_q[0] <= rd_dat_d[0];
                rd_dat_q[1] <= rd_dat_d[1];
                rd_busy_q   <= rd_busy_d;
            end
        end
    end

    assign readOut_1 = rd_dat_q[0];
    assign readOut_2 = rd_dat_q[1];
    assign busy_1    = rd_busy_q[0];
    assign busy_2    = rd_busy_q[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed test of reg_file_sb in three configurations.
// Latency: checks sample 1 time unit after the posedge that captured the read.
// Backpressure: not applicable; inputs are driven just after each posedge.

module tb_reg_file_sb;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Shared stimulus for the BYPASS=1 and BYPASS=0 instances
    logic        rst, re, we, mark_en;
    logic [4:0]  readSel_1, readSel_2, writeSel, mark_sel;
    logic [31:0] data;

    logic [31:0] byp_rd1, byp_rd2, nob_rd1, nob_rd2;
    logic        byp_b1, byp_b2, nob_b1, nob_b2;

    // Small instance: 16 bits x 12 registers, 4-bit selects
    logic        s_re, s_we, s_mk;
    logic [3:0]  s_rs1, s_rs2, s_ws, s_ms;
    logic [15:0] s_wd;
    logic [15:0] s_rd1, s_rd2;
    logic        s_b1, s_b2;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_sb #(.BYPASS(1)) u_byp (
        .clock(clock), .rst(rst), .re(re),
        .readSel_1(readSel_1), .readSel_2(readSel_2),
        .readOut_1(byp_rd1), .readOut_2(byp_rd2),
        .busy_1(byp_b1), .busy_2(byp_b2),
        .we(we), .writeSel(writeSel), .data(data),
        .mark_en(mark_en), .mark_sel(mark_sel)
    );

    reg_file_sb #(.BYPASS(0)) u_nob (
        .clock(clock), .rst(rst), .re(re),
        .readSel_1(readSel_1), .readSel_2(readSel_2),
        .readOut_1(nob_rd1), .readOut_2(nob_rd2),
        .busy_1(nob_b1), .busy_2(nob_b2),
        .we(we), .writeSel(writeSel), .data(data),
        .mark_en(mark_en), .mark_sel(mark_sel)
    );

    reg_file_sb #(.DATA_WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4)) u_small (
        .clock(clock), .rst(rst), .re(s_re),
        .readSel_1(s_rs1), .readSel_2(s_rs2),
        .readOut_1(s_rd1), .readOut_2(s_rd2),
        .busy_1(s_b1), .busy_2(s_b2),
        .we(s_we), .writeSel(s_ws), .data(s_wd),
        .mark_en(s_mk), .mark_sel(s_ms)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; mark_en = 1'b0;
        readSel_1 = '0; readSel_2 = '0; writeSel = '0; mark_sel = '0; data = '0;
        s_re = 1'b0; s_we = 1'b0; s_mk = 1'b0;
        s_rs1 = '0; s_rs2 = '0; s_ws = '0; s_ms = '0; s_wd = '0;
        step();
        rst = 1'b0;
        chk("reset_rd1", byp_rd1, 32'h0);
        chk("reset_b1", {31'b0, byp_b1}, 32'h0);
        chk("reset_small_rd1", {16'h0, s_rd1}, 32'h0);

        // Reset then read
        re = 1'b1; readSel_1 = 5'd5; readSel_2 = 5'd31;
        step();
        chk("rst_read_rd1", byp_rd1, 32'h0);
        chk("rst_read_rd2", byp_rd2, 32'h0);
        chk("rst_read_b1", {31'b0, byp_b1}, 32'h0);
        chk("rst_read_b2", {31'b0, byp_b2}, 32'h0);

        // Write then read
        re = 1'b0; we = 1'b1; writeSel = 5'd7; data = 32'hDEADBEEF;
        step();
        we = 1'b0; re = 1'b1; readSel_1 = 5'd7;
        step();
        chk("wr_rd_byp", byp_rd1, 32'hDEADBEEF);
        chk("wr_rd_nob", nob_rd1, 32'hDEADBEEF);

        // Zero register: write and mark are both dropped
        re = 1'b0; we = 1'b1; writeSel = 5'd0; data = 32'hFFFFFFFF;
        mark_en = 1'b1; mark_sel = 5'd0;
        step();
        we = 1'b0; mark_en = 1'b0; re = 1'b1; readSel_1 = 5'd0; readSel_2 = 5'd0;
        step();
        chk("zero_rd1", byp_rd1, 32'h0);
        chk("zero_rd2", byp_rd2, 32'h0);
        chk("zero_b1", {31'b0, byp_b1}, 32'h0);

        // Same-cycle write and read of r3
        we = 1'b1; writeSel = 5'd3; data = 32'h12345678;
        re = 1'b1; readSel_1 = 5'd7; readSel_2 = 5'd3;
        step();
        chk("bypass_on_rd2", byp_rd2, 32'h12345678);
        chk("bypass_off_rd2", nob_rd2, 32'h0);
        chk("bypass_other_port", nob_rd1, 32'hDEADBEEF);
        we = 1'b0;
        step();
        chk("bypass_off_next", nob_rd2, 32'h12345678);

        // Scoreboard: mark then read
        re = 1'b0; mark_en = 1'b1; mark_sel = 5'd9;
        step();
        mark_en = 1'b0; re = 1'b1; readSel_1 = 5'd9;
        step();
        chk("mark_b1_byp", {31'b0, byp_b1}, 32'h1);
        chk("mark_b1_nob", {31'b0, nob_b1}, 32'h1);

        // A mark is visible to a read in the same cycle
        mark_en = 1'b1; mark_sel = 5'd10; readSel_2 = 5'd10;
        step();
        chk("mark_fwd_byp", {31'b0, byp_b2}, 32'h1);
        chk("mark_fwd_nob", {31'b0, nob_b2}, 32'h1);
        mark_en = 1'b0;

        // Writeback clears busy; bypass shows it at once
        we = 1'b1; writeSel = 5'd9; data = 32'h000000A5; readSel_1 = 5'd9;
        step();
        chk("wb_byp_rd1", byp_rd1, 32'h000000A5);
        chk("wb_byp_b1", {31'b0, byp_b1}, 32'h0);
        chk("wb_nob_rd1_old", nob_rd1, 32'h0);
        chk("wb_nob_b1_old", {31'b0, nob_b1}, 32'h1);
        we = 1'b0;
        step();
        chk("wb_nob_rd1_new", nob_rd1, 32'h000000A5);
        chk("wb_nob_b1_new", {31'b0, nob_b1}, 32'h0);

        // Simultaneous write and mark: data stored, busy stays set
        re = 1'b0; we = 1'b1; writeSel = 5'd9; data = 32'h00000077;
        mark_en = 1'b1; mark_sel = 5'd9;
        step();
        we = 1'b0; mark_en = 1'b0; re = 1'b1; readSel_1 = 5'd9;
        step();
        chk("wm_rd1", byp_rd1, 32'h00000077);
        chk("wm_b1", {31'b0, byp_b1}, 32'h1);
        chk("wm_nob_b1", {31'b0, nob_b1}, 32'h1);

        // re=0 holds outputs even when selects move
        re = 1'b0; readSel_1 = 5'd7;
        step();
        chk("hold_rd1", byp_rd1, 32'h00000077);
        chk("hold_b1", {31'b0, byp_b1}, 32'h1);

        // Reset mid-operation drops the write and mark of that cycle
        rst = 1'b1; re = 1'b1; we = 1'b1; writeSel = 5'd4; data = 32'h0000AAAA;
        mark_en = 1'b1; mark_sel = 5'd4; readSel_1 = 5'd4;
        step();
        chk("midrst_rd1", byp_rd1, 32'h0);
        chk("midrst_b1", {31'b0, byp_b1}, 32'h0);
        rst = 1'b0; we = 1'b0; mark_en = 1'b0; readSel_1 = 5'd4; readSel_2 = 5'd7;
        step();
        chk("postrst_rd1", byp_rd1, 32'h0);
        chk("postrst_b1", {31'b0, byp_b1}, 32'h0);
        chk("postrst_rd2", byp_rd2, 32'h0);

        // Both ports on the same address
        re = 1'b0; we = 1'b1; writeSel = 5'd20; data = 32'hCAFEF00D;
        step();
        we = 1'b0; re = 1'b1; readSel_1 = 5'd20; readSel_2 = 5'd20;
        step();
        chk("same_sel_rd1", byp_rd1, 32'hCAFEF00D);
        chk("same_sel_rd2", byp_rd2, 32'hCAFEF00D);

        // Small configuration: 16 x 12, address 13 is out of range
        s_we = 1'b1; s_ws = 4'd11; s_wd = 16'hBEEF;
        step();
        s_ws = 4'd13; s_wd = 16'h1111;
        step();
        s_we = 1'b0; s_re = 1'b1; s_rs1 = 4'd11; s_rs2 = 4'd13;
        step();
        chk("small_rd11", {16'h0, s_rd1}, 32'h0000BEEF);
        chk("small_rd13", {16'h0, s_rd2}, 32'h0);
        s_re = 1'b0; s_rs1 = 4'd13; s_rs2 = 4'd11; s_we = 1'b1; s_ws = 4'd11; s_wd = 16'h0000;
        step();
        chk("small_hold_rd1", {16'h0, s_rd1}, 32'h0000BEEF);
        chk("small_hold_rd2", {16'h0, s_rd2}, 32'h0);
        s_we = 1'b0; s_mk = 1'b1; s_ms = 4'd11; s_re = 1'b1; s_rs1 = 4'd11; s_rs2 = 4'd13;
        step();
        chk("small_rd11_new", {16'h0, s_rd1}, 32'h0);
        chk("small_b11", {31'b0, s_b1}, 32'h1);
        s_mk = 1'b1; s_ms = 4'd14; s_rs2 = 4'd14;
        s_we = 1'b1; s_ws = 4'd13; s_wd = 16'h1234; s_rs1 = 4'd13;
        step();
        chk("small_oor_bypass", {16'h0, s_rd1}, 32'h0);
        chk("small_oor_mark", {31'b0, s_b2}, 32'h0);
        s_mk = 1'b0; s_we = 1'b0; s_rs2 = 4'd11;
        step();
        chk("small_b11_kept", {31'b0, s_b2}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the lab5 32x32 register file. It is a multi-width, multi-depth register file with two registered read ports and a posedge write port. It adds optional write-to-read bypass and a per-register busy scoreboard for pipeline hazard tracking. It sits between decode (read/mark) and writeback (write) in the pipelined CPU datapath.

Parameters:
DATA_WIDTH, 32, bits per register
DEPTH, 32, number of registers; legal range 2..2^ADDR_WIDTH
ADDR_WIDTH, 5, width of every select port
ZERO_REG, 1, 1 = register 0 hardwired to zero, never writable, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address

Ports:
clock  input  1  single clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
re  input  1  read enable; 0 = read outputs hold
readSel_1  input  ADDR_WIDTH  read port 1 address
readSel_2  input  ADDR_WIDTH  read port 2 address
readOut_1  output  DATA_WIDTH  registered read data, port 1
readOut_2  output  DATA_WIDTH  registered read data, port 2
busy_1  output  1  registered busy flag of readSel_1 address
busy_2  output  1  registered busy flag of readSel_2 address
we  input  1  write enable
writeSel  input  ADDR_WIDTH  write address
data  input  DATA_WIDTH  write data
mark_en  input  1  set busy bit of mark_sel (producer issued)
mark_sel  input  ADDR_WIDTH  register to mark busy

Behaviour:
- One clock, posedge only; reset is synchronous and active-high. On posedge with rst=1: every register and every busy bit is cleared, readOut_1/2=0, busy_1/2=0. rst overrides we, mark_en and re in the same cycle.
- Write: posedge with we=1 stores data into reg[writeSel] and clears busy[writeSel].
- Ignored writes: writeSel>=DEPTH, or writeSel==0 when ZERO_REG=1. These have no effect on any state.
- Mark: posedge with mark_en=1 sets busy[mark_sel]. The mark is ignored for an out-of-range address, and for address 0 when ZERO_REG=1.
- Write and mark to the same address in the same cycle: data is stored and busy ends at 1 (mark wins; a new producer has been issued).
- Read: posedge with re=1 captures readOut_n <= value(readSel_n) and busy_n <= busyval(readSel_n). Latency is 1 cycle from the select to the output. When re=0, all four read outputs hold.
- value(a):
  - 0 if a>=DEPTH, or if a==0 with ZERO_REG=1;
  - else data if BYPASS=1 and we=1 and writeSel==a (a qualifying write);
  - else reg[a].
- busyval(a):
  - 0 if a is out of range or is the zero register;
  - else 1 if mark_en=1 and mark_sel==a;
  - else 0 if BYPASS=1 and a qualifying write targets a;
  - else busy[a].
- BYPASS=0: reads in the same cycle as a write to the same address return the old contents and the old busy bit. The new value is visible on the next read cycle.
- Both read ports are fully independent; readSel_1==readSel_2 is legal and both ports return identical values.
- Reset mid-operation: a write or mark presented in the rst cycle is lost; the first post-reset read of any address returns 0 with busy 0.
- No combinational path from any input to any output. All outputs come from flops.

Test Plan:
- Reset then read: rst=1 for one cycle, then re=1, readSel_1=5, readSel_2=31 -> next cycle readOut_1=0, readOut_2=0, busy_1=busy_2=0.
- Write then read: we=1, writeSel=7, data=32'hDEADBEEF; next cycle re=1, readSel_1=7 -> one cycle later readOut_1=32'hDEADBEEF.
- Zero register: we=1, writeSel=0, data=32'hFFFFFFFF, mark_en=1, mark_sel=0; then read address 0 -> readOut=0, busy=0.
- Bypass with BYPASS=1: same cycle we=1, writeSel=3, data=32'h12345678, re=1, readSel_2=3 -> next cycle readOut_2=32'h12345678. Repeat with BYPASS=0 and reg3=0 -> readOut_2=0, then 32'h12345678 on the following read.
- Scoreboard:
  - mark_en=1, mark_sel=9, then read 9 -> busy_1=1.
  - we=1, writeSel=9, data=32'hA5 with re=1, readSel_1=9 (BYPASS=1) -> busy_1=0, readOut_1=32'hA5.
  - Simultaneous mark and write to 9 -> busy stays 1 and the data is stored.
- Parametrisation: DATA_WIDTH=16, DEPTH=12, ADDR_WIDTH=4. Write 16'hBEEF to 11, then write 16'h1111 to 13 -> read 11 returns 16'hBEEF, read 13 returns 0; re=0 holds the previous outputs unchanged.
